// File: rtl/lock_pkg.sv
// Shared types and helpers for the code-entry lock: FSM state encoding,
// key-width helper and a one-hot to index encoder with a validity flag.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    OPEN,
    LOCKOUT
  } state_t;

  // Widest key bus the encoder handles.
  localparam int MAX_KEYS = 32;

  // Bits needed to hold a digit index for an n-key bus (at least one bit).
  function automatic int key_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic       valid;
    logic [4:0] index;
  } key_index_t;

  // Index of the set bit; valid only when exactly one bit is set.
  function automatic key_index_t onehot_to_index(input logic [MAX_KEYS-1:0] v);
    key_index_t r;
    int         cnt;
    r.valid = 1'b0;
    r.index = '0;
    cnt     = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (v[i]) begin
        cnt     = cnt + 1;
        r.index = 5'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/code_entry_fsm_if.sv
// Key/timing and status bundle between the lock top level and the
// code-entry FSM. The master side supplies keys, timeout and code.
interface code_entry_fsm_if #(
  parameter int N      = 4,
  parameter int DIGITS = 4
);
  localparam int KW = lock_pkg::key_width(N);
  localparam int CW = $clog2(DIGITS + 1);

  logic [N-1:0]         key;
  logic                 timeout;
  logic [DIGITS*KW-1:0] code;
  logic                 unlocked;
  logic                 alarm;
  logic                 err;
  logic [CW-1:0]        digit_cnt;

  modport master (
    output key, timeout, code,
    input  unlocked, alarm, err, digit_cnt
  );

  modport slave (
    input  key, timeout, code,
    output unlocked, alarm, err, digit_cnt
  );
endinterface

// File: rtl/key_press_detect.sv
// Turns raw key levels into single-cycle press events with the pressed
// digit encoded. A press needs the bus to have been all-zero last cycle.
module key_press_detect
  import lock_pkg::*;
#(
  parameter int N  = 4,
  parameter int KW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  key,
  output logic          press,
  output logic [KW-1:0] digit,
  output logic          digit_valid
);

  logic [N-1:0] key_prev;
  key_index_t   enc;

  // Track last key level; reset loads the live level so a key held
  // through reset release is not seen as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_prev <= key;
    end else begin
      key_prev <= key;
    end
  end

  // Edge detect and encode the current key level.
  always_comb begin
    enc         = onehot_to_index(MAX_KEYS'(key));
    press       = (key != '0) && (key_prev == '0);
    digit       = KW'(enc.index);
    digit_valid = enc.valid;
  end

endmodule

// File: rtl/code_entry_fsm.sv
// Code-entry lock controller: collects DIGITS key presses, compares them
// digit by digit against the supplied code, opens on a match, pulses err
// on a miss and locks out after MAX_TRIES consecutive misses.
module code_entry_fsm
  import lock_pkg::*;
#(
  parameter int N           = 4,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 20
) (
  input  logic             clock,
  input  logic             reset,
  code_entry_fsm_if.slave  bus
);

  localparam int KW = key_width(N);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t        state;
  logic [TW-1:0] tries;
  logic [31:0]   timer;
  logic          match;
  logic [CW-1:0] digit_cnt;
  logic          unlocked;
  logic          alarm;
  logic          err;

  logic          press;
  logic [KW-1:0] digit;
  logic          digit_valid;

  logic [KW-1:0] expected_digit;
  logic          new_match;
  logic          last_digit;
  int            cmp_idx;

  key_press_detect #(
    .N  (N),
    .KW (KW)
  ) u_key_press_detect (
    .clock       (clock),
    .reset       (reset),
    .key         (bus.key),
    .press       (press),
    .digit       (digit),
    .digit_valid (digit_valid)
  );

  // Compare the pressed digit with its slot in the live code; an attempt
  // starting from IDLE begins with a fresh match flag.
  always_comb begin
    cmp_idx        = (state == IDLE) ? 0 : int'(digit_cnt);
    expected_digit = '0;
    if (cmp_idx < DIGITS) begin
      expected_digit = bus.code[cmp_idx*KW +: KW];
    end
    new_match  = ((state == IDLE) ? 1'b1 : match) && digit_valid && (digit == expected_digit);
    last_digit = ((digit_cnt + CW'(1)) == CW'(DIGITS));
  end

  // Main lock FSM with registered outputs, counters and attempt tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tries     <= '0;
      timer     <= '0;
      match     <= 1'b1;
      digit_cnt <= '0;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (press) begin
            if (last_digit) begin
              digit_cnt <= '0;
              match     <= 1'b1;
              if (new_match) begin
                state    <= OPEN;
                tries    <= '0;
                timer    <= '0;
                unlocked <= 1'b1;
              end else begin
                err   <= 1'b1;
                tries <= tries + TW'(1);
                if (tries == TW'(MAX_TRIES - 1)) begin
                  state <= LOCKOUT;
                  timer <= '0;
                  alarm <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              state     <= ENTRY;
              digit_cnt <= digit_cnt + CW'(1);
              match     <= new_match;
            end
          end else if (state == ENTRY && bus.timeout) begin
            // Idle too long: drop the partial attempt without penalty.
            state     <= IDLE;
            digit_cnt <= '0;
            match     <= 1'b1;
          end
        end
        OPEN: begin
          timer <= timer + 32'd1;
          if (press || timer == 32'(OPEN_CYCLES - 1)) begin
            state    <= IDLE;
            unlocked <= 1'b0;
          end
        end
        LOCKOUT: begin
          timer <= timer + 32'd1;
          if (timer == 32'(LOCK_CYCLES - 1)) begin
            state <= IDLE;
            tries <= '0;
            alarm <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.unlocked  = unlocked;
  assign bus.alarm     = alarm;
  assign bus.err       = err;
  assign bus.digit_cnt = digit_cnt;

endmodule

// File: tb/tb_code_entry_fsm.sv
// Directed and randomized bench for code_entry_fsm against a behavioural
// model that keeps a list of per-press correctness and countdown timers.
module tb_code_entry_fsm;

  logic clock;
  logic reset;

  code_entry_fsm_if #(.N(4), .DIGITS(4)) bus ();

  code_entry_fsm #(
    .N(4), .DIGITS(4), .MAX_TRIES(3), .OPEN_CYCLES(8), .LOCK_CYCLES(20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [7:0] cur_code;
  logic [3:0] prev_m;
  int         q_ok[$];
  int         tries_m;
  int         open_left;
  int         lock_left;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_edge(input logic [3:0] k, input logic t, input logic r);
    logic press;
    int   idx;
    int   ok;
    exp_err = 1'b0;
    if (r) begin
      prev_m = k;
      q_ok.delete();
      tries_m = 0; open_left = 0; lock_left = 0;
      return;
    end
    press  = (k != 4'd0) && (prev_m == 4'd0);
    prev_m = k;
    if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) tries_m = 0;
    end else if (open_left > 0) begin
      if (press) open_left = 0;
      else open_left--;
    end else if (press) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (k[i]) idx = i;
      ok = ($countones(k) == 1) && (idx == int'((cur_code >> (2 * q_ok.size())) & 8'd3));
      q_ok.push_back(ok);
      if (q_ok.size() == 4) begin
        if (q_ok.sum() == 4) begin
          open_left = 8;
          tries_m   = 0;
        end else begin
          exp_err = 1'b1;
          tries_m++;
          if (tries_m == 3) lock_left = 20;
        end
        q_ok.delete();
      end
    end else if (t && q_ok.size() > 0) begin
      q_ok.delete();
    end
  endtask

  task automatic step(input logic [3:0] k, input logic t, input logic r);
    @(negedge clock);
    bus.key     = k;
    bus.timeout = t;
    bus.code    = cur_code;
    reset       = r;
    @(posedge clock);
    model_edge(k, t, r);
    #1;
    check("unlocked",  32'(bus.unlocked),  32'(open_left > 0));
    check("alarm",     32'(bus.alarm),     32'(lock_left > 0));
    check("err",       32'(bus.err),       32'(exp_err));
    check("digit_cnt", 32'(bus.digit_cnt), 32'(q_ok.size()));
  endtask

  task automatic press(input logic [3:0] k);
    step(k, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    logic [3:0] k;
    cur_code    = 8'b00_11_10_01;  // digits 1,2,3,0
    bus.key     = 4'd0;
    bus.timeout = 1'b0;
    bus.code    = cur_code;
    reset       = 1'b1;
    prev_m      = 4'd0;
    tries_m     = 0; open_left = 0; lock_left = 0; exp_err = 1'b0;

    // Key held through reset release is not a press
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    idle(2);
    $display("txn: reset with key held");

    // Correct code opens for 8 cycles
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    idle(10);
    $display("txn: correct entry");

    // One wrong code, then two more for lockout with presses ignored
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    idle(2);
    $display("txn: wrong code 1");
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    for (int i = 0; i < 11; i++) press(4'b0010);
    idle(2);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    idle(10);
    $display("txn: lockout then unlock");

    // Timeout abandons the attempt
    press(4'b0010); press(4'b0100);
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    idle(10);
    $display("txn: timeout abandon");

    // Press and timeout together: press wins
    press(4'b0010); press(4'b0100);
    step(4'b1000, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    press(4'b0001);
    idle(10);
    $display("txn: press with timeout");

    // Non-one-hot key forces a mismatch
    enter(4'b0010, 4'b0100, 4'b0110, 4'b0001);
    idle(2);
    $display("txn: multi-bit key");

    // Press during OPEN relocks
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    idle(3);
    press(4'b0010);
    idle(3);
    $display("txn: press during open");

    // Reset during lockout clears tries
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    idle(5);
    step(4'd0, 1'b0, 1'b1);
    idle(3);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0010);
    idle(2);
    enter(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    idle(10);
    $display("txn: reset during lockout");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_code = 8'($urandom);
      if ($urandom_range(0, 9) < 6) k = 4'd0;
      else if ($urandom_range(0, 9) == 0) k = 4'($urandom);
      else k = 4'd1 << $urandom_range(0, 3);
      step(k, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end
    $display("txn: random traffic done");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/code_entry_fsm.md
Name: code_entry_fsm

Overview:
- Consumer side of the digital-lock key/timing interface. Takes raw key levels plus the idle-timeout level `t` from the key-timing block.
- Assembles key presses into a DIGITS-long code and compares it to a supplied code.
- Drives `unlocked`, `err` and `alarm` for the lock top level.
- Tracks failed attempts and enforces a lockout period.

Parameters:
- N, 4: key bus width, one-hot keys; digit value = bit index.
- DIGITS, 4: code length in digits.
- MAX_TRIES, 3: consecutive wrong codes before lockout.
- OPEN_CYCLES, 8: cycles `unlocked` stays high.
- LOCK_CYCLES, 20: cycles of lockout with `alarm` high.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key  in  N  key levels, one-hot when pressed, 0 when released.
- timeout  in  1  idle-timeout level from the key-timing block (its `t`).
- code  in  DIGITS*KW  expected code; KW = clog2(N). Digit 0 occupies the LSBs and is entered first.
- unlocked  out  1  high while in OPEN.
- alarm  out  1  high while in LOCKOUT.
- err  out  1  one-cycle pulse on a wrong complete code.
- digit_cnt  out  clog2(DIGITS+1)  digits entered in the current attempt.

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset:
  - state=IDLE; unlocked=0, alarm=0, err=0, digit_cnt=0; tries=0; timer=0; match=1.
  - key_prev loads the current `key`, so a key held through reset release is not a press.
- Press event: key!=0 && key_prev==0. key_prev <= key every cycle.
  - Digit value = index of the set bit.
  - Non-one-hot key at press (≥2 bits) is a valid press with forced mismatch.
  - Held keys generate no further events; a press requires release to 0 first.
- Comparison: digit k is checked against code[k*KW +: KW]. match &= (valid && equal). Registered, no lookahead.
- IDLE:
  - On press: go to ENTRY, digit_cnt=1, match = compare(digit 0).
  - If DIGITS==1, evaluate completion in the same cycle, as in ENTRY.
- ENTRY:
  - On press: digit_cnt+1, match update.
  - When the press makes digit_cnt reach DIGITS, evaluate the final match (including this digit):
    - Match: go to OPEN, tries=0, timer=0.
    - Mismatch: err=1 next cycle for exactly 1 cycle; tries+1; if tries+1==MAX_TRIES go to LOCKOUT (timer=0), else go to IDLE. digit_cnt=0, match=1.
  - timeout high with no press this cycle: abandon to IDLE, digit_cnt=0, match=1; tries unchanged, no err.
  - Press and timeout in the same cycle: press wins, timeout ignored.
- OPEN:
  - unlocked=1. timer counts up each cycle.
  - At timer==OPEN_CYCLES-1, go to IDLE next cycle; unlocked is therefore high for exactly OPEN_CYCLES cycles.
  - A press in OPEN relocks immediately (go to IDLE). The press is consumed and not counted as a digit.
  - timeout ignored.
- LOCKOUT:
  - alarm=1; all presses ignored but key_prev still tracks `key`.
  - After LOCK_CYCLES cycles go to IDLE, tries=0, alarm=0.
  - timeout ignored.
- Output timing: all outputs registered. unlocked/alarm assert the cycle after the transition edge. err coincides with the first cycle of the following state.
- Widths: timer 32 bits unsigned with no wrap in use; tries clog2(MAX_TRIES+1) bits.
- `code` is sampled combinationally at each compare and may change between presses.
- Reset mid-attempt, mid-OPEN or mid-LOCKOUT returns everything to reset values on the next edge; tries is cleared.

Decomposition:
- Package lock_pkg:
  - state enum {IDLE, ENTRY, OPEN, LOCKOUT}.
  - KW localparam helper (clog2 of N).
  - onehot_to_index function with a valid flag.
- Sub-module key_press_detect:
  - Contains key_prev, edge detect and encoding.
  - Outputs press, digit[KW-1:0], digit_valid.
- The FSM, counters and comparison stay in code_entry_fsm.

Test Plan:
All tests use N=4, DIGITS=4, code digits 1,2,3,0; keys 0010, 0100, 1000, 0001 with release between presses.
- Correct entry: enter 0010, 0100, 1000, 0001 -> digit_cnt 1,2,3,4→0; unlocked high for exactly 8 cycles starting the cycle after the 4th press edge; err never pulses.
- Wrong code: enter 0010, 0100, 1000, 0010 -> err one-cycle pulse, unlocked stays 0, state IDLE, tries=1. Three consecutive wrong codes -> alarm high for 20 cycles, presses during it ignored (digit_cnt stays 0), then alarm=0 and a correct code unlocks.
- Timeout abandon: enter 0010, 0100, then assert timeout with no press -> digit_cnt returns to 0, no err, tries unchanged; a fresh correct code then unlocks.
- Simultaneous press and timeout: 3rd digit press on the same edge as timeout=1 -> digit_cnt=3, attempt continues; completing it with 0001 unlocks.
- Edge cases:
  - key 0110 pressed as digit 2 -> forced mismatch, err on completion.
  - key held at 0010 through reset release -> no press, digit_cnt=0.
  - Press during OPEN -> unlocked drops next cycle, digit_cnt stays 0.
  - Reset asserted mid-LOCKOUT -> alarm=0 next cycle, tries=0.
